hazard_sched: RTL and testbench

- Central pipeline scheduler for the 5-stage MIPS core: F, D, E, M, W.
- Replaces the per-stage ad-hoc hazard counters with one block that decides stalls, bubbles, flushes and forwarding selects.
- Sequences multi-cycle execute ops (mult/div unit) and keeps performance counters.
- Sits beside the pipeline registers; every stage register consumes its Stall*/Flush* enable from here.

---
 rtl/hazard_pkg.sv | 17 +
 rtl/fwd_sel.sv | 23 ++
 rtl/hazard_sched.sv | 162 ++++++++++++++++
 tb/tb_hazard_sched.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard scheduler: FSM states,
// forwarding mux selects and the hard-wired zero register.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_WAIT  = 2'd1,
    BR_FLUSH = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_sel.sv
// Forwarding select for one E-stage source operand. M beats W so the
// youngest value wins; loads in M are not forwarded, and $0 never is.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] i_srcReg,
  input  logic [4:0] i_writeRegM,
  input  logic       i_regWriteM,
  input  logic       i_memtoRegM,
  input  logic [4:0] i_writeRegW,
  input  logic       i_regWriteW,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_regWriteM && (i_writeRegM != REG_ZERO) && (i_writeRegM == i_srcReg) && !i_memtoRegM)
      o_fwd = FWD_M;
    else if (i_regWriteW && (i_writeRegW != REG_ZERO) && (i_writeRegW == i_srcReg))
      o_fwd = FWD_W;
  end

endmodule

// File: rtl/hazard_sched.sv
// Central stall/flush/forward scheduler for the 5-stage pipeline, with
// mult/div sequencing, a wait watchdog and stall/flush performance counters.
module hazard_sched
  import hazard_pkg::*;
#(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic             UsesRsD,
  input  logic             UsesRtD,
  input  logic             JumpD,
  input  logic [4:0]       RsE,
  input  logic [4:0]       RtE,
  input  logic [4:0]       WriteRegE,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MdStartE,
  input  logic             MdDone,
  input  logic [4:0]       WriteRegM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic             BranchTakenM,
  input  logic [4:0]       WriteRegW,
  input  logic             RegWriteW,
  input  logic             CntClr,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MdKill,
  output logic             MdTimeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt,
  output logic [1:0]       State
);

  localparam int WD_W = $clog2(MD_TIMEOUT) + 1;

  state_t           r_state;
  state_t           w_nextState;
  logic [WD_W-1:0]  r_wd;
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;
  logic             r_mdTimeout;

  logic w_luE;
  logic w_luM;
  logic w_lu;
  logic w_md;
  logic w_wdExpired;
  logic w_timeoutFire;

  fwd_sel u_fwdA (
    .i_srcReg   (RsE),
    .i_writeRegM(WriteRegM),
    .i_regWriteM(RegWriteM),
    .i_memtoRegM(MemtoRegM),
    .i_writeRegW(WriteRegW),
    .i_regWriteW(RegWriteW),
    .o_fwd      (ForwardAE)
  );

  fwd_sel u_fwdB (
    .i_srcReg   (RtE),
    .i_writeRegM(WriteRegM),
    .i_regWriteM(RegWriteM),
    .i_memtoRegM(MemtoRegM),
    .i_writeRegW(WriteRegW),
    .i_regWriteW(RegWriteW),
    .o_fwd      (ForwardBE)
  );

  assign w_luE = RegWriteE && MemtoRegE && (WriteRegE != REG_ZERO) &&
                 ((UsesRsD && (RsD == WriteRegE)) || (UsesRtD && (RtD == WriteRegE)));
  assign w_luM = RegWriteM && MemtoRegM && (WriteRegM != REG_ZERO) &&
                 ((UsesRsD && (RsD == WriteRegM)) || (UsesRtD && (RtD == WriteRegM)));

  // D and E hold bubbles during BR_FLUSH, so hazards seen there are stale.
  assign w_lu          = (r_state != BR_FLUSH) && (w_luE || w_luM);
  assign w_wdExpired   = (r_state == MD_WAIT) && (r_wd == WD_W'(MD_TIMEOUT - 1));
  assign w_md          = ((r_state == RUN) && MdStartE) ||
                         ((r_state == MD_WAIT) && !MdDone && !w_wdExpired);
  assign w_timeoutFire = w_wdExpired && !BranchTakenM;

  always_comb begin
    w_nextState = r_state;
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    MdKill = 1'b0;

    case (r_state)
      RUN: begin
        if (BranchTakenM)            w_nextState = BR_FLUSH;
        else if (MdStartE && !MdDone) w_nextState = MD_WAIT;
      end
      MD_WAIT: begin
        if (BranchTakenM)              w_nextState = BR_FLUSH;
        else if (MdDone || w_wdExpired) w_nextState = RUN;
      end
      default: w_nextState = RUN;
    endcase

    if (Rst) begin
      if (BranchTakenM) begin
        FlushD = 1'b1;
        FlushE = 1'b1;
        MdKill = (r_state == MD_WAIT);
      end else if (w_md) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        FlushM = 1'b1;
      end else if (w_lu) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end else if (JumpD) begin
        FlushD = 1'b1;
      end
      if (w_timeoutFire) MdKill = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state     <= RUN;
      r_wd        <= '0;
      r_stallCnt  <= '0;
      r_flushCnt  <= '0;
      r_mdTimeout <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_wd    <= ((r_state == MD_WAIT) && (w_nextState == MD_WAIT)) ? r_wd + WD_W'(1) : '0;
      if (w_timeoutFire) r_mdTimeout <= 1'b1;
      if (CntClr) begin
        r_stallCnt <= '0;
        r_flushCnt <= '0;
      end else begin
        if (StallF)       r_stallCnt <= r_stallCnt + CNT_W'(1);
        if (BranchTakenM) r_flushCnt <= r_flushCnt + CNT_W'(1);
      end
    end
  end

  assign State     = r_state;
  assign StallCnt  = r_stallCnt;
  assign FlushCnt  = r_flushCnt;
  assign MdTimeout = r_mdTimeout;

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: forwarding table, hand-written
// multi-cycle sequences, then random traffic against a rule-level model.
module tb_hazard_sched;

  localparam int TO = 8;
  localparam int CW = 8;

  typedef struct {
    logic [4:0] rsD, rtD;
    logic       usesRsD, usesRtD, jumpD;
    logic [4:0] rsE, rtE, writeRegE;
    logic       regWriteE, memtoRegE, mdStartE, mdDone;
    logic [4:0] writeRegM;
    logic       regWriteM, memtoRegM, branchTakenM;
    logic [4:0] writeRegW;
    logic       regWriteW, cntClr;
  } stim_t;

  typedef struct {
    stim_t      in;
    logic [1:0] expA, expB;
  } fwdVec_t;

  typedef struct {
    logic stallF, stallD, stallE, flushD, flushE, flushM, mdKill;
  } snap_t;

  logic Clk = 1'b0;
  logic Rst;
  stim_t cur;
  snap_t snap;

  logic StallF, StallD, StallE, FlushD, FlushE, FlushM, MdKill, MdTimeout;
  logic [1:0] ForwardAE, ForwardBE, State;
  logic [CW-1:0] StallCnt, FlushCnt;

  int errors = 0;
  int checks = 0;

  // Reference model state: 0 = running, 1 = waiting on mult/div, 2 = post-branch cycle
  int mState, mWd;
  bit mTimeout;
  logic [CW-1:0] mStallCnt, mFlushCnt;
  int pState, pWd;
  bit pTimeout;
  logic [CW-1:0] pStallCnt, pFlushCnt;

  hazard_sched #(.MD_TIMEOUT(TO), .CNT_W(CW)) dut (
    .Clk(Clk), .Rst(Rst),
    .RsD(cur.rsD), .RtD(cur.rtD), .UsesRsD(cur.usesRsD), .UsesRtD(cur.usesRtD),
    .JumpD(cur.jumpD), .RsE(cur.rsE), .RtE(cur.rtE), .WriteRegE(cur.writeRegE),
    .RegWriteE(cur.regWriteE), .MemtoRegE(cur.memtoRegE), .MdStartE(cur.mdStartE),
    .MdDone(cur.mdDone), .WriteRegM(cur.writeRegM), .RegWriteM(cur.regWriteM),
    .MemtoRegM(cur.memtoRegM), .BranchTakenM(cur.branchTakenM),
    .WriteRegW(cur.writeRegW), .RegWriteW(cur.regWriteW), .CntClr(cur.cntClr),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .MdKill(MdKill), .MdTimeout(MdTimeout),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    return s;
  endfunction

  function automatic stim_t mkFwd(input int wM, input bit rwM, input bit mtrM,
                                  input int wW, input bit rwW, input int rs, input int rt);
    stim_t s;
    s = idle();
    s.writeRegM = 5'(wM); s.regWriteM = rwM; s.memtoRegM = mtrM;
    s.writeRegW = 5'(wW); s.regWriteW = rwW;
    s.rsE = 5'(rs); s.rtE = 5'(rt);
    return s;
  endfunction

  function automatic logic [1:0] fwdRef(input stim_t s, input logic [4:0] src);
    if (src == 0) return 2'b00;
    if (s.regWriteM && !s.memtoRegM && s.writeRegM == src) return 2'b10;
    if (s.regWriteW && s.writeRegW == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit dependsOn(input stim_t s, input logic [4:0] r);
    return (r != 0) && ((s.usesRsD && s.rsD == r) || (s.usesRtD && s.rtD == r));
  endfunction

  task automatic modelReset();
    mState = 0; mWd = 0; mTimeout = 0; mStallCnt = '0; mFlushCnt = '0;
  endtask

  task automatic checkOutput(input stim_t s);
    bit br, expired, md, lu;
    bit eSF, eSD, eSE, eFD, eFE, eFM, eKill;
    br = s.branchTakenM;
    expired = (mState == 1) && (mWd == TO - 1);
    md = (mState == 0 && s.mdStartE) || (mState == 1 && !s.mdDone && !expired);
    lu = (mState != 2) &&
         ((s.regWriteE && s.memtoRegE && dependsOn(s, s.writeRegE)) ||
          (s.regWriteM && s.memtoRegM && dependsOn(s, s.writeRegM)));
    {eSF, eSD, eSE, eFD, eFE, eFM} = '0;
    if (br)          begin eFD = 1; eFE = 1; end
    else if (md)     begin eSF = 1; eSD = 1; eSE = 1; eFM = 1; end
    else if (lu)     begin eSF = 1; eSD = 1; eFE = 1; end
    else if (s.jumpD) eFD = 1;
    eKill = br ? (mState == 1) : expired;

    check("StallF", StallF, eSF);
    check("StallD", StallD, eSD);
    check("StallE", StallE, eSE);
    check("FlushD", FlushD, eFD);
    check("FlushE", FlushE, eFE);
    check("FlushM", FlushM, eFM);
    check("MdKill", MdKill, eKill);
    check("ForwardAE", ForwardAE, fwdRef(s, s.rsE));
    check("ForwardBE", ForwardBE, fwdRef(s, s.rtE));
    check("State", State, mState);
    check("StallCnt", StallCnt, mStallCnt);
    check("FlushCnt", FlushCnt, mFlushCnt);
    check("MdTimeout", MdTimeout, mTimeout);

    if (br)                                pState = 2;
    else if (mState == 0)                  pState = (s.mdStartE && !s.mdDone) ? 1 : 0;
    else if (mState == 1)                  pState = (s.mdDone || expired) ? 0 : 1;
    else                                   pState = 0;
    if (mState == 2)                       pState = 0;
    pWd       = (mState == 1 && pState == 1) ? mWd + 1 : 0;
    pTimeout  = mTimeout || (!br && expired);
    pStallCnt = s.cntClr ? '0 : mStallCnt + CW'(eSF);
    pFlushCnt = s.cntClr ? '0 : mFlushCnt + CW'(br);
  endtask

  // One clock: drive at the falling edge, check mid-cycle, advance the model after the rising edge.
  task automatic applyStimulus(input stim_t s);
    @(negedge Clk);
    cur = s;
    #1;
    snap = '{StallF, StallD, StallE, FlushD, FlushE, FlushM, MdKill};
    checkOutput(s);
    @(posedge Clk);
    #1;
    mState = pState; mWd = pWd; mTimeout = pTimeout;
    mStallCnt = pStallCnt; mFlushCnt = pFlushCnt;
  endtask

  fwdVec_t fwdTable[8];
  stim_t s;
  int killAt, stallSeen;
  bit killed;

  initial begin
    fwdTable[0] = '{mkFwd(5, 1, 0, 5, 1, 5, 5),   2'b10, 2'b10};
    fwdTable[1] = '{mkFwd(0, 1, 0, 0, 1, 0, 0),   2'b00, 2'b00};
    fwdTable[2] = '{mkFwd(5, 1, 1, 5, 1, 5, 6),   2'b01, 2'b00};
    fwdTable[3] = '{mkFwd(7, 1, 0, 4, 1, 4, 7),   2'b01, 2'b10};
    fwdTable[4] = '{mkFwd(5, 0, 0, 5, 0, 5, 5),   2'b00, 2'b00};
    fwdTable[5] = '{mkFwd(9, 0, 0, 9, 1, 9, 9),   2'b01, 2'b01};
    fwdTable[6] = '{mkFwd(31, 1, 0, 0, 1, 31, 0), 2'b10, 2'b00};
    fwdTable[7] = '{mkFwd(2, 1, 0, 3, 1, 3, 3),   2'b01, 2'b01};

    // Reset with every hazard source active: outputs must stay quiet.
    cur = idle();
    cur.regWriteE = 1; cur.memtoRegE = 1; cur.writeRegE = 3;
    cur.rsD = 3; cur.usesRsD = 1; cur.mdStartE = 1; cur.branchTakenM = 1; cur.jumpD = 1;
    Rst = 1'b0;
    #3;
    check("rstState", State, 0);
    check("rstStallCnt", StallCnt, 0);
    check("rstFlushCnt", FlushCnt, 0);
    check("rstMdTimeout", MdTimeout, 0);
    check("rstQuiet", {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdKill}, 0);
    @(negedge Clk);
    cur = idle();
    Rst = 1'b1;
    modelReset();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(fwdTable[i].in);
      check($sformatf("fwdA[%0d]", i), ForwardAE, fwdTable[i].expA);
      check($sformatf("fwdB[%0d]", i), ForwardBE, fwdTable[i].expB);
    end

    // Load followed by a dependent instruction: two stall cycles.
    s = idle(); s.cntClr = 1;
    applyStimulus(s);
    s = idle(); s.regWriteE = 1; s.memtoRegE = 1; s.writeRegE = 3; s.rsD = 3; s.usesRsD = 1;
    applyStimulus(s);
    check("luStall1", {snap.stallF, snap.stallD, snap.flushE, snap.stallE}, 4'b1110);
    s = idle(); s.regWriteM = 1; s.memtoRegM = 1; s.writeRegM = 3; s.rsD = 3; s.usesRsD = 1;
    applyStimulus(s);
    check("luStall2", {snap.stallF, snap.stallD, snap.flushE, snap.stallE}, 4'b1110);
    s = idle(); s.regWriteW = 1; s.writeRegW = 3; s.rsD = 3; s.usesRsD = 1;
    applyStimulus(s);
    check("luRelease", {snap.stallF, snap.stallD, snap.flushE}, 3'b000);
    check("luStallCnt", StallCnt, 2);

    // Mult/div completing on the fifth wait cycle.
    s = idle(); s.mdStartE = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(s);
      check($sformatf("mdStall[%0d]", i), {snap.stallE, snap.flushM}, 2'b11);
      check($sformatf("mdWaitState[%0d]", i), State, 1);
    end
    s.mdDone = 1;
    applyStimulus(s);
    check("mdDoneRelease", {snap.stallF, snap.stallE, snap.flushM}, 3'b000);
    check("mdDoneState", State, 0);

    // Watchdog: mult/div never finishes.
    s = idle(); s.cntClr = 1;
    applyStimulus(s);
    s = idle(); s.mdStartE = 1;
    killed = 0; killAt = -1; stallSeen = 0;
    for (int i = 0; i < 20 && !killed; i++) begin
      applyStimulus(s);
      if (snap.mdKill) begin killed = 1; killAt = i; end
      else stallSeen += int'(snap.stallF);
    end
    check("wdKillCycle", killAt, 8);
    check("wdStallCycles", stallSeen, 8);
    check("wdTimeoutSet", MdTimeout, 1);
    check("wdState", State, 0);
    check("wdStallCnt", StallCnt, 8);
    s = idle(); s.cntClr = 1;
    applyStimulus(s);
    check("wdStickyAfterClr", MdTimeout, 1);
    check("wdClrStallCnt", StallCnt, 0);

    // Branch resolves during the second wait cycle.
    s = idle(); s.mdStartE = 1;
    applyStimulus(s);
    applyStimulus(s);
    s.branchTakenM = 1;
    applyStimulus(s);
    check("brFlush", {snap.flushD, snap.flushE, snap.mdKill}, 3'b111);
    check("brNoStall", {snap.stallF, snap.stallD, snap.stallE}, 3'b000);
    check("brState", State, 2);
    applyStimulus(idle());
    check("brBackToRun", State, 0);
    check("brFlushCnt", FlushCnt, 1);

    // Asynchronous reset between edges while waiting on mult/div.
    s = idle(); s.mdStartE = 1;
    applyStimulus(s);
    applyStimulus(s);
    #2;
    Rst = 1'b0;
    #1;
    check("arstState", State, 0);
    check("arstQuiet", {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdKill}, 0);
    check("arstCounters", {StallCnt, FlushCnt}, 0);
    check("arstTimeout", MdTimeout, 0);
    @(negedge Clk);
    cur = idle();
    Rst = 1'b1;
    modelReset();

    for (int i = 0; i < 1000; i++) begin
      s = idle();
      s.rsD = 5'($urandom_range(0, 3)); s.rtD = 5'($urandom_range(0, 3));
      s.usesRsD = 1'($urandom); s.usesRtD = 1'($urandom);
      s.jumpD = ($urandom_range(0, 7) == 0);
      s.rsE = 5'($urandom_range(0, 3)); s.rtE = 5'($urandom_range(0, 3));
      s.writeRegE = 5'($urandom_range(0, 3));
      s.regWriteE = 1'($urandom); s.memtoRegE = ($urandom_range(0, 2) == 0);
      s.mdStartE = ($urandom_range(0, 7) == 0); s.mdDone = ($urandom_range(0, 4) == 0);
      s.writeRegM = 5'($urandom_range(0, 3));
      s.regWriteM = 1'($urandom); s.memtoRegM = ($urandom_range(0, 2) == 0);
      s.branchTakenM = ($urandom_range(0, 15) == 0);
      s.writeRegW = 5'($urandom_range(0, 3)); s.regWriteW = 1'($urandom);
      s.cntClr = ($urandom_range(0, 199) == 0);
      applyStimulus(s);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
